instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch stage feeding the single-cycle 18-bit CPU datapath. Owns the 10-bit program counter, issues reads to a 1-cycle-latency instruction memory, and buffers returned words in a small FIFO. The FIFO presents {pc, instruction} to decode over a valid/ready handshake. Taken branches and jumps from execute redirect the PC, which flushes the buffer and any in-flight read.

## Interface
- ADDR_W, 10, PC / instruction-memory address width
- INSTR_W, 18, instruction width
- RESET_PC, 0, PC value after reset
- DEPTH, 2, buffer entries (power of two, ≥2)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address; equals the PC register
- imem_rdata  in  INSTR_W  read data; valid the cycle after imem_req
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  ADDR_W  target PC
- halt  in  1  suppress new requests; drain continues
- instr_valid  out  1  buffer head valid
- instr_ready  in  1  decode accepts the head
- instr_data  out  INSTR_W  head instruction
- instr_pc  out  ADDR_W  address of the head instruction

## Operation
- State:
  - pc (ADDR_W)
  - inflight flag (1 bit)
  - buffer of DEPTH {pc, instr} entries, with rd_ptr, wr_ptr, and count (0..DEPTH)
- pop = instr_valid && instr_ready.
- Issue condition, evaluated combinationally:
  - imem_req = !reset && !redirect_valid && !halt && (count + inflight − pop) < DEPTH.
  - The pop credit allows one instruction per cycle in steady state.
- On issue:
  - pc <= pc + 1, modulo 2^ADDR_W (1023 → 0).
  - inflight <= 1, and the issued address is recorded as the tag.
  - Without issue, inflight <= 0.
- Response:
  - If inflight was 1 at the start of the cycle, imem_rdata and the tag are written into the buffer at wr_ptr.
  - If inflight is 0, imem_rdata is ignored.
- Pop:
  - rd_ptr advances.
  - Simultaneous pop and write leaves count unchanged.
- Redirect (highest priority after reset):
  - pc <= redirect_pc.
  - count, pointers, and inflight are cleared.
  - No issue that cycle, so the response arriving next cycle is discarded.
  - A pop in the same cycle is still a completed handshake for decode; the buffer is flushed regardless.
  - Redirect during halt updates pc; no issue occurs until halt falls.
- Halt:
  - Blocks only new issues.
  - An in-flight response is still captured, and buffered entries still drain.
- Stability: while instr_valid && !instr_ready, instr_data and instr_pc hold stable.
- No overflow: the issue condition guarantees a write never finds the buffer full.

## Timing
- Reset values:
  - pc = RESET_PC; imem_addr = RESET_PC
  - imem_req = 0, instr_valid = 0, inflight = 0, count = 0
  - instr_data = 0, instr_pc = 0
- Startup: reset is deasserted in cycle 0. First request is in cycle 0, data arrives in cycle 1, and instr_valid is high in cycle 2 (pc = RESET_PC).
- Throughput: one instruction per cycle with instr_ready held high.
- Redirect latency: redirect in cycle t, request for the target in t+1, instr_valid with instr_pc = redirect_pc in t+3.
- Reset mid-operation: next cycle is identical to post-reset. Buffer empty, in-flight response dropped, request from RESET_PC.
- instr_valid is purely registered (count != 0); it has no combinational path from imem_rdata.

## Structure
- Shared package cpu_pkg holds:
  - ADDR_W, INSTR_W, RESET_PC
  - opcode field position [17:14]
  - typedef fetch_entry_t {pc, instr}, shared with decode
- Sub-module fetch_buffer: DEPTH-entry synchronous FIFO of fetch_entry_t.
  - Inputs: push, pop, flush.
  - Outputs: count and head.
  - The top level holds pc, the inflight tag, and the issue logic.

## Test plan
- Startup: reset 2 cycles, imem model returns addr + 0x100, ready = 1. instr_valid from cycle 2; instr_pc 0,1,2,3… one per cycle; instr_data = pc + 0x100.
- Backpressure: ready low 5 cycles after the first valid. count saturates at 2, imem_req low, head stable at pc 0. On release, pcs are consecutive with no loss or duplication.
- Redirect with read in flight to 0x200 at cycle t. Stale response dropped, no old pc appears after t. Next instr_valid at t+3 with instr_pc = 0x200.
- Wrap: redirect to 1022. Sequence 1022, 1023, 0, 1.
- Halt with full buffer:
  - No imem_req while halted; 2 entries drain.
  - Redirect to 0x050 mid-halt.
  - After halt drops, first instr_pc = 0x050.
- Reset with full buffer and read in flight. Next cycle instr_valid = 0. Request at RESET_PC; first valid instr_pc = 0 two cycles after deassertion.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch/decode widths, reset PC, opcode field and the fetch_entry_t {pc, instr} record
package cpu_pkg;
  localparam int ADDR_W = 10;
  localparam int INSTR_W = 18;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;
  localparam int OP_HI = 17;
  localparam int OP_LO = 14;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
  function automatic logic [OP_HI-OP_LO:0] opcode(input logic [INSTR_W-1:0] i);
    return i[OP_HI:OP_LO];
  endfunction
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of fetch_entry_t (clk/reset, push+din, pop, flush in; count and zeroed-when-empty head out)
module fetch_buffer
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  din,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);
  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = din;
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end
  assign count = count_q;
  assign head = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC + 1-cycle imem issue (imem_req/addr/rdata), redirect/halt control, buffered {pc,instr} to decode via valid/ready
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [ADDR_W-1:0] pc_q, pc_d, tag_q, tag_d;
  logic inflight_q, inflight_d, pop;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t din, head;
  assign pop = instr_valid && instr_ready;
  always_comb begin
    occ = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    imem_req = !reset && !redirect_valid && !halt && (occ < (CW+1)'(DEPTH));
    pc_d = redirect_valid ? redirect_pc : imem_req ? pc_q + ADDR_W'(1) : pc_q;
    inflight_d = imem_req;
    tag_d = pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      tag_q <= tag_d;
    end
  end
  assign din = '{pc: tag_q, instr: imem_rdata};
  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .push(inflight_q),
    .pop(pop),
    .flush(redirect_valid),
    .din(din),
    .count(count),
    .head(head)
  );
  assign imem_addr = pc_q;
  assign instr_valid = count != '0;
  assign instr_data = head.instr;
  assign instr_pc = head.pc;
endmodule
